// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA/HDMI raster timing generator
//
// Purpose: free-running pixel/line counters with registered blanking, sync,
//          display-enable, line/frame start pulses and a frame counter.
//          Every flag is decoded from the next-count values so it lines up
//          with the hcount/vcount presented in the same cycle.
// Ports:
//   pclk        in   pixel clock, rising edge
//   rst         in   synchronous active-high reset (wins over ce)
//   ce          in   pixel clock enable
//   hcount      out  current pixel column
//   vcount      out  current line
//   hsync/vsync out  sync pulses at HS_POL/VS_POL level
//   hblnk/vblnk out  horizontal/vertical blanking
//   de          out  display enable (active area)
//   line_start  out  one-cycle pulse when hcount wraps to 0
//   frame_start out  one-cycle pulse when (hcount,vcount) wraps to (0,0)
//   frame_cnt   out  completed-frame counter, modulo 2^FRM_W
module vga_timing_gen #(
  parameter int H_ACTIVE = 1920,
  parameter int H_FP     = 88,
  parameter int H_SYNC   = 44,
  parameter int H_BP     = 148,
  parameter int V_ACTIVE = 1080,
  parameter int V_FP     = 4,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 36,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1,
  parameter int CNT_W    = 12,
  parameter int FRM_W    = 8
) (
  input  logic             pclk,
  input  logic             rst,
  input  logic             ce,
  output logic [CNT_W-1:0] hcount,
  output logic [CNT_W-1:0] vcount,
  output logic             hsync,
  output logic             vsync,
  output logic             hblnk,
  output logic             vblnk,
  output logic             de,
  output logic             line_start,
  output logic             frame_start,
  output logic [FRM_W-1:0] frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam bit BAD_PARAMS = (H_ACTIVE == 0) || (H_FP == 0) || (H_SYNC == 0) ||
                              (H_BP == 0) || (V_ACTIVE == 0) || (V_FP == 0) ||
                              (V_SYNC == 0) || (V_BP == 0) ||
                              (H_TOTAL > (1 << CNT_W)) || (V_TOTAL > (1 << CNT_W));

  if (BAD_PARAMS) begin : g_bad_params
    $error("vga_timing_gen: illegal timing parameters");
  end

  // Window boundaries as CNT_W-wide constants. The back porch is at least one
  // pixel/line, so the sync end boundary always fits in CNT_W bits.
  localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT_END  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_END  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_START   = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END     = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START   = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END     = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [CNT_W-1:0] hcount_q, hcount_d;
  logic [CNT_W-1:0] vcount_q, vcount_d;
  logic [FRM_W-1:0] frame_cnt_q, frame_cnt_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             hblnk_q, hblnk_d;
  logic             vblnk_q, vblnk_d;
  logic             de_q, de_d;
  logic             line_start_q, line_start_d;
  logic             frame_start_q, frame_start_d;
  logic             hs_win, vs_win;

  always_comb begin
    hcount_d      = hcount_q;
    vcount_d      = vcount_q;
    frame_cnt_d   = frame_cnt_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;

    if (rst) begin
      hcount_d    = '0;
      vcount_d    = '0;
      frame_cnt_d = '0;
    end else if (ce) begin
      if (hcount_q == H_LAST) begin
        hcount_d     = '0;
        line_start_d = 1'b1;
        if (vcount_q == V_LAST) begin
          vcount_d      = '0;
          frame_start_d = 1'b1;
          frame_cnt_d   = frame_cnt_q + FRM_W'(1);
        end else begin
          vcount_d = vcount_q + CNT_W'(1);
        end
      end else begin
        hcount_d = hcount_q + CNT_W'(1);
      end
    end

    // Decoding the next counts keeps the flags aligned with the counters;
    // with ce low the counts hold, so the level flags hold too.
    hs_win  = (hcount_d >= HS_START) && (hcount_d < HS_END);
    vs_win  = (vcount_d >= VS_START) && (vcount_d < VS_END);
    hblnk_d = (hcount_d >= H_ACT_END);
    vblnk_d = (vcount_d >= V_ACT_END);
    de_d    = !hblnk_d && !vblnk_d;
    hsync_d = HS_POL ? hs_win : !hs_win;
    vsync_d = VS_POL ? vs_win : !vs_win;
  end

  always_ff @(posedge pclk) begin
    hcount_q      <= hcount_d;
    vcount_q      <= vcount_d;
    frame_cnt_q   <= frame_cnt_d;
    hsync_q       <= hsync_d;
    vsync_q       <= vsync_d;
    hblnk_q       <= hblnk_d;
    vblnk_q       <= vblnk_d;
    de_q          <= de_d;
    line_start_q  <= line_start_d;
    frame_start_q <= frame_start_d;
  end

  assign hcount      = hcount_q;
  assign vcount      = vcount_q;
  assign frame_cnt   = frame_cnt_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign hblnk       = hblnk_q;
  assign vblnk       = vblnk_q;
  assign de          = de_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter H_ACTIVE, 1920, visible pixels per line.
REQ-002 Parameter H_FP, 88, horizontal front porch in pixels.
REQ-003 Parameter H_SYNC, 44, horizontal sync width in pixels.
REQ-004 Parameter H_BP, 148, horizontal back porch in pixels.
REQ-005 Parameter V_ACTIVE, 1080, visible lines per frame.
REQ-006 Parameter V_FP, 4, vertical front porch in lines.
REQ-007 Parameter V_SYNC, 5, vertical sync width in lines.
REQ-008 Parameter V_BP, 36, vertical back porch in lines.
REQ-009 Parameter HS_POL, 1, hsync active level (1 = active-high, 0 = active-low).
REQ-010 Parameter VS_POL, 1, vsync active level (same encoding as HS_POL).
REQ-011 Parameter CNT_W, 12, width of hcount and vcount; SHALL hold H_TOTAL-1 and V_TOTAL-1.
REQ-012 Parameter FRM_W, 8, width of frame_cnt.
REQ-013 pclk  in  1  pixel clock, all logic on its rising edge.
REQ-014 rst  in  1  synchronous, active-high reset.
REQ-015 ce  in  1  pixel clock enable; the counters advance only when it is high.
REQ-016 hcount  out  CNT_W  current pixel column.
REQ-017 vcount  out  CNT_W  current line.
REQ-018 hsync, vsync  out  1 each  sync pulses at the HS_POL/VS_POL level.
REQ-019 hblnk, vblnk, de  out  1 each  horizontal blank, vertical blank, and display enable.
REQ-020 line_start, frame_start  out  1 each  single-cycle pulses.
REQ-021 frame_cnt  out  FRM_W  completed-frame counter.

Function
REQ-022 Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
REQ-023 On a cycle with ce=1, hcount SHALL increment by 1; at H_TOTAL-1 it SHALL wrap to 0 and vcount SHALL advance on the same edge.
REQ-024 vcount SHALL increment on each hcount wrap; at V_TOTAL-1 it SHALL wrap to 0 on the same edge that hcount wraps.
REQ-025 On a cycle with ce=0, hcount, vcount, frame_cnt and all level outputs SHALL hold their values.
REQ-026 All outputs SHALL be registered and SHALL have zero skew relative to hcount/vcount: each flag describes the count values presented in the same cycle. Flags SHALL be decoded from the next-count values.
REQ-027 hblnk SHALL equal hcount >= H_ACTIVE; vblnk SHALL equal vcount >= V_ACTIVE; de SHALL equal !hblnk && !vblnk.
REQ-028 hsync SHALL be active for H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC and inactive otherwise.
REQ-029 vsync SHALL be active for V_ACTIVE+V_FP <= vcount < V_ACTIVE+V_FP+V_SYNC; it changes only on an hcount wrap edge.
REQ-030 line_start SHALL be 1 for exactly one cycle when hcount becomes 0 by wrap.
REQ-031 frame_start SHALL be 1 for exactly one cycle when hcount and vcount become (0,0) by wrap; line_start is also 1 in that cycle.
REQ-032 Both pulses SHALL be 0 in any cycle that follows a ce=0 cycle, so each event produces one pulse only.
REQ-033 frame_cnt SHALL increment modulo 2^FRM_W on each frame wrap; it wraps from all-ones to 0 silently.
REQ-034 Illegal parameters (any timing field equal to 0, or a total that exceeds 2^CNT_W) SHALL raise a simulation-time error at elaboration; synthesis behaviour for them is undefined.

Reset
REQ-035 While rst=1 on a pclk edge, the following SHALL hold on the next cycle: hcount=0, vcount=0, frame_cnt=0, hblnk=0, vblnk=0, de=1, line_start=0, frame_start=0, hsync=!HS_POL, vsync=!VS_POL.
REQ-036 rst SHALL take priority over ce; a reset mid-line or mid-frame SHALL restart at (0,0) with no pulse.
REQ-037 The first frame_start after reset SHALL occur at the first full-frame wrap.

Verification
REQ-038 Default parameters, ce=1, 2 frames -> hsync high for hcount 2008..2051; vsync high for vcount 1084..1088; 2200x1125 cycles per frame; frame_cnt=2.
REQ-039 HS_POL=0, VS_POL=0 -> hsync and vsync are low only inside the same windows; they are high out of reset.
REQ-040 ce toggled 1,0,1,0 -> counts advance every other cycle; exactly one line_start per line; no duplicate pulses.
REQ-041 rst asserted at hcount=1000, vcount=500 -> next cycle (0,0), frame_cnt=0, both pulses 0.
REQ-042 Small config (H=8/2/2/2, V=4/1/1/1, FRM_W=2), 5 frames -> H_TOTAL=14, V_TOTAL=7; frame_cnt sequence 1,2,3,0,1; de asserted 32 cycles per frame.
REQ-043 At wrap (2199,1124)->(0,0) -> frame_start=1, line_start=1, vblnk=0, de=1 in the same cycle.
